// File: rtl/fsm_step_ctrl.sv
// Step sequencer for the table-driven datapath: debounced buttons drive single-step,
// free-run and run-until-breakpoint modes, issuing one-clock step_en pulses.
module fsm_step_ctrl #(
    parameter int unsigned STATE_W      = 3,
    parameter int unsigned DEBOUNCE_CYC = 3,
    parameter int unsigned RATE_DIV     = 25,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_btn,
    input  logic               run_btn,
    input  logic               bp_en,
    input  logic [STATE_W-1:0] bp_state,
    input  logic [STATE_W-1:0] cur_state,
    output logic               step_en,
    output logic               running,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   step_count
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned DIV_W = $clog2(RATE_DIV);
    localparam int unsigned NBTN  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [NBTN-1:0]   btn_raw, sync1, sync2, db, db_d;
    logic [DB_W-1:0]   db_cnt [NBTN];
    logic [DIV_W-1:0]  div;
    logic              step_en_n;
    logic              div_clr;
    logic              step_press_c, run_press_c;
    logic              wrap_c, bp_match_c;

    assign btn_raw = {run_btn, step_btn};

    // Per-button synchronizer, debouncer and delayed level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_cnt[i] <= '0;
                    db[i]     <= ~db[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign step_press_c = db[0] & ~db_d[0];
    assign run_press_c  = db[1] & ~db_d[1];
    assign wrap_c       = (div == DIV_W'(RATE_DIV - 1));
    assign bp_match_c   = bp_en && (cur_state == bp_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and step request; run press always outranks step press and breakpoint
    always_comb begin
        state_n   = state;
        step_en_n = 1'b0;
        div_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_press_c) begin
                    state_n = S_RUN;
                    div_clr = 1'b1;
                end else if (step_press_c) begin
                    step_en_n = 1'b1;
                end
            end
            S_RUN: begin
                if (run_press_c) begin
                    state_n = S_IDLE;
                    div_clr = 1'b1;
                end else if (step_en) begin
                    state_n = S_CHECK;
                end else if (wrap_c) begin
                    step_en_n = 1'b1;
                end
            end
            S_CHECK: begin
                if (run_press_c) begin
                    state_n = S_IDLE;
                    div_clr = 1'b1;
                end else if (bp_match_c) begin
                    state_n = S_HALT;
                end else begin
                    state_n   = S_RUN;
                    step_en_n = wrap_c;
                end
            end
            S_HALT: begin
                if (run_press_c) begin
                    state_n = S_RUN;
                    div_clr = 1'b1;
                end else if (step_press_c) begin
                    state_n   = S_IDLE;
                    step_en_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Rate divider runs only in RUN/CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (div_clr || !(state == S_RUN || state == S_CHECK) || wrap_c) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Registered outputs follow the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_en    <= 1'b0;
            running    <= 1'b0;
            bp_hit     <= 1'b0;
            step_count <= '0;
        end else begin
            step_en <= step_en_n;
            running <= (state_n == S_RUN) || (state_n == S_CHECK);
            bp_hit  <= (state_n == S_HALT);
            if (step_en_n && (step_count != {CNT_W{1'b1}})) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Directed bench for fsm_step_ctrl: button timing, run cadence, breakpoint halt/resume,
// async reset and step_count saturation (CNT_W=3).
module tb_fsm_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_btn = 1'b0;
    logic       run_btn = 1'b0;
    logic       bp_en = 1'b0;
    logic [2:0] bp_state = 3'd0;
    logic [2:0] cur_state = 3'd0;
    logic       step_en, running, bp_hit;
    logic [2:0] step_count;

    logic       dp_load = 1'b0;
    logic [2:0] dp_val = 3'd0;

    logic       run_hist [0:127];
    logic       hit_hist [0:127];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses, first_e, last_e, total;

    fsm_step_ctrl #(
        .STATE_W(3), .DEBOUNCE_CYC(3), .RATE_DIV(25), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn),
        .bp_en(bp_en), .bp_state(bp_state), .cur_state(cur_state),
        .step_en(step_en), .running(running), .bp_hit(bp_hit), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Datapath state register model
    always @(posedge clk) begin
        if (dp_load) cur_state <= dp_val;
        else if (step_en) cur_state <= cur_state + 3'd1;
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step n edges, logging outputs; buttons released after edge rel_at
    task automatic run_edges(input int n, input int rel_at,
                             output int p, output int f, output int l);
        p = 0; f = 0; l = 0;
        for (int e = 1; e <= n; e++) begin
            tick();
            run_hist[e] = running;
            hit_hist[e] = bp_hit;
            if (step_en) begin
                p++;
                if (f == 0) f = e;
                l = e;
            end
            if (e == rel_at) begin
                step_btn = 1'b0;
                run_btn  = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check_val("rst_step_en", step_en, 0);
        check_val("rst_running", running, 0);
        check_val("rst_bp_hit", bp_hit, 0);
        check_val("rst_count", step_count, 0);
        rst = 1'b0;
        tick();

        // Clean single step press held 10 clocks
        step_btn = 1'b1;
        run_edges(10, 0, pulses, first_e, last_e);
        check_val("step_edge", first_e, 6);
        check_val("step_pulses", pulses, 1);
        check_val("step_count1", step_count, 1);
        step_btn = 1'b0;
        run_edges(10, 0, pulses, first_e, last_e);
        check_val("release_pulses", pulses, 0);

        // Two-clock glitch
        step_btn = 1'b1;
        run_edges(12, 2, pulses, first_e, last_e);
        check_val("glitch_pulses", pulses, 0);

        // Simultaneous run+step: run wins, then free-run every 25 clocks
        step_btn = 1'b1;
        run_btn  = 1'b1;
        run_edges(85, 10, pulses, first_e, last_e);
        check_val("sim_run_e5", run_hist[5], 0);
        check_val("sim_run_e6", run_hist[6], 1);
        check_val("run_first", first_e, 31);
        check_val("run_last", last_e, 81);
        check_val("run_pulses", pulses, 3);
        check_val("run_count", step_count, 4);

        // Stop
        run_btn = 1'b1;
        run_edges(40, 10, pulses, first_e, last_e);
        check_val("stop_run_e5", run_hist[5], 1);
        check_val("stop_run_e6", run_hist[6], 0);
        check_val("stop_pulses", pulses, 0);

        // Breakpoint at 5 starting from 2
        dp_val  = 3'd2;
        dp_load = 1'b1;
        tick();
        dp_load  = 1'b0;
        bp_en    = 1'b1;
        bp_state = 3'd5;
        check_val("dp_loaded", cur_state, 2);
        run_btn = 1'b1;
        run_edges(100, 10, pulses, first_e, last_e);
        check_val("bp_pulses", pulses, 3);
        check_val("bp_last", last_e, 81);
        check_val("bp_hit_e82", hit_hist[82], 0);
        check_val("bp_hit_e83", hit_hist[83], 1);
        check_val("bp_run_e83", run_hist[83], 0);
        check_val("bp_cur", cur_state, 5);
        check_val("bp_hit_hold", bp_hit, 1);
        check_val("bp_count_sat", step_count, 7);

        // Resume from breakpoint without re-halting
        run_btn = 1'b1;
        run_edges(60, 10, pulses, first_e, last_e);
        check_val("res_hit_e5", hit_hist[5], 1);
        check_val("res_hit_e6", hit_hist[6], 0);
        check_val("res_run_e6", run_hist[6], 1);
        check_val("res_first", first_e, 31);
        check_val("res_pulses", pulses, 2);
        check_val("res_cur", cur_state, 7);
        check_val("res_bp_hit", bp_hit, 0);

        // Async reset mid-RUN while step_en is high
        run_edges(21, 0, pulses, first_e, last_e);
        check_val("pre_rst_step_en", step_en, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_step_en", step_en, 0);
        check_val("arst_running", running, 0);
        check_val("arst_bp_hit", bp_hit, 0);
        check_val("arst_count", step_count, 0);
        tick();
        tick();
        rst   = 1'b0;
        bp_en = 1'b0;
        tick();

        // Nine single steps: count saturates at 7
        total = 0;
        for (int i = 1; i <= 9; i++) begin
            step_btn = 1'b1;
            run_edges(16, 8, pulses, first_e, last_e);
            total += pulses;
            check_val($sformatf("sat_count_%0d", i), step_count, (i < 7) ? i : 7);
        end
        check_val("sat_total_pulses", total, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
